// File: rtl/awg_pkg.sv
// Shared constants for the AWG DDS channel: waveform codes, dither LFSR
// constants and the offset-binary midscale helper.
package awg_pkg;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback taps bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/dds_sin_lut.sv
// Quarter-wave sine ROM with registered output; entries are computed at
// elaboration as round(FS*sin(pi/2*(i+0.5)/DEPTH)), FS = 2^DATA_W-1.
module dds_sin_lut
  import awg_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int  DEPTH   = 1 << ADDR_W;
  localparam real FS      = real'((1 << DATA_W) - 1);
  localparam real HALF_PI = 1.5707963267948966;

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANG = HALF_PI * (real'(i) + 0.5) / real'(DEPTH);
    localparam int  VAL = $rtoi(FS * $sin(ANG) + 0.5);
    assign rom[i] = VAL[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform source: shadowed settings, phase accumulator, 3-stage
// wave/scale pipeline to an offset-binary DAC word. Build macro DDS_DITHER_EN adds LFSR phase dither.
module dds_wave_gen
  import awg_pkg::*;
#(
  parameter int ACC_W       = 32,
  parameter int PHASE_W     = 12,
  parameter int DAC_W       = 14,
  parameter int AMP_W       = 8,
  parameter int SYNC_UPDATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [ACC_W-1:0]   freq_word,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [AMP_W-1:0]   amp,
  input  logic [1:0]         wave_sel,
  output logic               pending,
  output logic               wrap,
  output logic               valid,
  output logic [DAC_W-1:0]   dac_out
);

  localparam int W1     = (DAC_W + 1 > PHASE_W) ? DAC_W + 1 : PHASE_W;
  localparam int LUT_AW = PHASE_W - 2;
  localparam int PW     = DAC_W + AMP_W + 2;
  localparam logic                    SYNC   = (SYNC_UPDATE != 0);
  localparam logic [DAC_W-1:0]        MID    = DAC_W'(midscale(DAC_W));
  localparam logic signed [DAC_W-1:0] FS_POS = DAC_W'(midscale(DAC_W) - 1);
  localparam logic signed [DAC_W-1:0] FS_NEG = DAC_W'(1 - midscale(DAC_W));

  logic [ACC_W-1:0]   sh_freq, act_freq;
  logic [PHASE_W-1:0] sh_phase, act_phase;
  logic [AMP_W-1:0]   sh_amp, act_amp;
  logic [1:0]         sh_wave, act_wave;
  logic               upd_req;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     acc_sum;
  logic               carry, apply;

  assign acc_sum = {1'b0, acc} + {1'b0, act_freq};
  assign carry   = acc_sum[ACC_W];
  // Synchronous mode holds new settings until the edge that overflows the
  // accumulator; a stopped channel has no wrap to wait for, so it applies at once.
  assign apply   = upd_req & (~SYNC | ~en | carry);
  assign pending = upd_req & SYNC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_freq   <= '0;
      sh_phase  <= '0;
      sh_amp    <= '0;
      sh_wave   <= WAVE_SINE;
      act_freq  <= '0;
      act_phase <= '0;
      act_amp   <= '0;
      act_wave  <= WAVE_SINE;
      upd_req   <= 1'b0;
    end else begin
      if (load) begin
        sh_freq  <= freq_word;
        sh_phase <= phase_off;
        sh_amp   <= amp;
        sh_wave  <= wave_sel;
      end
      if (apply) begin
        act_freq  <= sh_freq;
        act_phase <= sh_phase;
        act_amp   <= sh_amp;
        act_wave  <= sh_wave;
      end
      if (load) upd_req <= 1'b1;
      else if (apply) upd_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      acc  <= acc_sum[ACC_W-1:0];
      wrap <= carry;
    end else begin
      acc  <= '0;
      wrap <= 1'b0;
    end
  end

  // Top W1 phase bits; phase_off lands on the top PHASE_W of them.
  logic [W1-1:0] phase_top;

`ifdef DDS_DITHER_EN
  logic [15:0]      lfsr;
  logic [ACC_W-1:0] dith, acc_dith;
  logic             unused_dith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (en) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end

  assign dith        = ACC_W'(lfsr) & ((ACC_W'(1) << (ACC_W - PHASE_W)) - ACC_W'(1));
  assign acc_dith    = acc + dith;
  assign phase_top   = acc_dith[ACC_W-1 -: W1] + (W1'(act_phase) << (W1 - PHASE_W));
  assign unused_dith = ^acc_dith[ACC_W-W1-1:0];
`else
  assign phase_top   = acc[ACC_W-1 -: W1] + (W1'(act_phase) << (W1 - PHASE_W));
`endif

  // Stage 1: phase plus the settings that travel with this sample.
  logic [W1-1:0]    ph1;
  logic [1:0]       wave1;
  logic [AMP_W-1:0] amp1;
  logic             v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1   <= '0;
      wave1 <= WAVE_SINE;
      amp1  <= '0;
      v1    <= 1'b0;
    end else begin
      ph1   <= phase_top;
      wave1 <= act_wave;
      amp1  <= act_amp;
      v1    <= en;
    end
  end

  logic [PHASE_W-1:0] p1;
  logic [LUT_AW-1:0]  lut_addr;
  logic [DAC_W-2:0]   lut_data;
  logic [DAC_W-1:0]   tri_u, tri_t, saw_v;

  assign p1       = ph1[W1-1 -: PHASE_W];
  assign lut_addr = p1[PHASE_W-2] ? ~p1[PHASE_W-3:0] : p1[PHASE_W-3:0];
  assign tri_u    = ph1[W1-2 -: DAC_W];
  assign tri_t    = ph1[W1-1] ? ~tri_u : tri_u;
  assign saw_v    = ph1[W1-1 -: DAC_W];

  dds_sin_lut #(
    .ADDR_W (LUT_AW),
    .DATA_W (DAC_W - 1)
  ) u_sin_lut (
    .clk  (clk),
    .addr (lut_addr),
    .data (lut_data)
  );

  // Stage 2: non-sine shapes computed here; sine data arrives from the ROM register.
  logic signed [DAC_W-1:0] s2;
  logic                    neg2;
  logic [1:0]              wave2;
  logic [AMP_W-1:0]        amp2;
  logic                    v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2    <= '0;
      neg2  <= 1'b0;
      wave2 <= WAVE_SINE;
      amp2  <= '0;
      v2    <= 1'b0;
    end else begin
      case (wave1)
        WAVE_SQUARE: s2 <= p1[PHASE_W-1] ? FS_NEG : FS_POS;
        WAVE_TRI:    s2 <= {~tri_t[DAC_W-1], tri_t[DAC_W-2:0]};
        WAVE_SAW:    s2 <= {~saw_v[DAC_W-1], saw_v[DAC_W-2:0]};
        default:     s2 <= '0;
      endcase
      neg2  <= p1[PHASE_W-1];
      wave2 <= wave1;
      amp2  <= amp1;
      v2    <= v1;
    end
  end

  // Stage 3: gain (amp+1)/2^AMP_W with floor, then offset-binary.
  logic signed [DAC_W-1:0] lut_s, s3;
  logic [AMP_W:0]          amp_p1;
  logic signed [PW-1:0]    prod;
  logic [DAC_W-1:0]        y;
  logic                    unused_prod;

  assign lut_s       = signed'({1'b0, lut_data});
  assign s3          = (wave2 == WAVE_SINE) ? (neg2 ? -lut_s : lut_s) : s2;
  assign amp_p1      = {1'b0, amp2} + (AMP_W + 1)'(1);
  assign prod        = PW'(s3) * PW'(signed'({1'b0, amp_p1}));
  assign y           = prod[AMP_W +: DAC_W];
  assign unused_prod = ^{prod[PW-1 -: 2], prod[AMP_W-1:0]};

  // valid marks dac_out as a generated sample; there is no ready, the DAC takes every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_out <= MID;
      valid   <= 1'b0;
    end else begin
      dac_out <= v2 ? (y + MID) : MID;
      valid   <= v2;
    end
  end

endmodule
